// File: rtl/tqvp_apu_pulse.sv
// 2A03-style pulse channel on the TinyQV byte bus: 4-bit sample + PWM bit on uo_out.
// Writes land on the next clk edge, reads are combinational, no backpressure (data_ready=1).
module tqvp_apu_pulse #(
   parameter int CPU_DIV    = 36,
   parameter int QFRAME_DIV = 7457
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);
   localparam int CW = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
   localparam int QW = (QFRAME_DIV > 1) ? $clog2(QFRAME_DIV) : 1;
   localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIV - 1);
   localparam logic [QW-1:0] QF_LAST  = QW'(QFRAME_DIV - 1);

   localparam logic [7:0] LEN_TABLE [32] = '{
      8'd10,  8'd254, 8'd20,  8'd2,  8'd40,  8'd4,  8'd80, 8'd6,
      8'd160, 8'd8,   8'd60,  8'd10, 8'd14,  8'd12, 8'd26, 8'd14,
      8'd12,  8'd16,  8'd24,  8'd18, 8'd48,  8'd20, 8'd96, 8'd22,
      8'd192, 8'd24,  8'd72,  8'd26, 8'd16,  8'd28, 8'd32, 8'd30};
   // bit 7 holds sequencer step 0
   localparam logic [7:0] DUTY_PAT [4] = '{
      8'b0100_0000, 8'b0110_0000, 8'b0111_1000, 8'b1001_1111};

   logic [CW-1:0] cdiv_q, cdiv_d;
   logic [QW-1:0] qf_cnt_q, qf_cnt_d;
   logic          apu_ph_q, apu_ph_d, hf_ph_q, hf_ph_d;
   logic [7:0]    ctrl_q, ctrl_d;
   logic [10:0]   period_q, period_d, timer_q, timer_d;
   logic [2:0]    step_q, step_d;
   logic          enable_q, enable_d, irq_en_q, irq_en_d, irq_q, irq_d;
   logic [7:0]    len_q, len_d;
   logic          env_start_q, env_start_d;
   logic [3:0]    decay_q, decay_d, env_div_q, env_div_d;
   logic [3:0]    pwm_q, pwm_d;

   logic       wr, cpu_tick, apu_tick, qf_tick, hf_tick, irq_set, len_nz, duty_bit;
   logic [7:0] wdat, rd_byte;
   logic [3:0] sample;
   logic       unused_ok;

   assign wr        = (data_write_n != 2'b11);
   assign wdat      = data_in[7:0];
   assign len_nz    = (len_q != 8'd0);
   assign unused_ok = &{1'b0, ui_in, data_in[31:8], data_read_n};

   always_comb begin
      cdiv_d      = cdiv_q;
      qf_cnt_d    = qf_cnt_q;
      apu_ph_d    = apu_ph_q;
      hf_ph_d     = hf_ph_q;
      ctrl_d      = ctrl_q;
      period_d    = period_q;
      timer_d     = timer_q;
      step_d      = step_q;
      enable_d    = enable_q;
      irq_en_d    = irq_en_q;
      irq_d       = irq_q;
      len_d       = len_q;
      env_start_d = env_start_q;
      decay_d     = decay_q;
      env_div_d   = env_div_q;
      pwm_d       = pwm_q + 4'd1;
      irq_set     = 1'b0;

      cpu_tick = (cdiv_q == CPU_LAST);
      apu_tick = cpu_tick & apu_ph_q;
      qf_tick  = cpu_tick & (qf_cnt_q == QF_LAST);
      hf_tick  = qf_tick & hf_ph_q;
      cdiv_d   = cpu_tick ? '0 : cdiv_q + CW'(1);
      apu_ph_d = apu_ph_q ^ cpu_tick;
      hf_ph_d  = hf_ph_q ^ qf_tick;
      if (cpu_tick) qf_cnt_d = qf_tick ? '0 : qf_cnt_q + QW'(1);

      if (apu_tick) begin
         if (timer_q == 11'd0) begin
            timer_d = period_q;
            step_d  = step_q - 3'd1;
         end else begin
            timer_d = timer_q - 11'd1;
         end
      end

      if (qf_tick) begin
         if (env_start_q) begin
            env_start_d = 1'b0;
            decay_d     = 4'd15;
            env_div_d   = ctrl_q[3:0];
         end else if (env_div_q == 4'd0) begin
            env_div_d = ctrl_q[3:0];
            if (decay_q != 4'd0)  decay_d = decay_q - 4'd1;
            else if (ctrl_q[5])   decay_d = 4'd15;
         end else begin
            env_div_d = env_div_q - 4'd1;
         end
      end

      if (hf_tick && len_nz && !ctrl_q[5]) begin
         len_d   = len_q - 8'd1;
         irq_set = (len_q == 8'd1) && irq_en_q;
      end

      // Register writes override the tick updates computed above
      if (wr) begin
         case (address)
            6'h00: ctrl_d = wdat;
            6'h01: period_d[7:0] = wdat;
            6'h02: begin
               period_d[10:8] = wdat[2:0];
               step_d         = 3'd0;
               env_start_d    = 1'b1;
               if (enable_q) begin
                  len_d   = LEN_TABLE[wdat[7:3]];
                  irq_set = 1'b0;
               end
            end
            6'h03: begin
               enable_d = wdat[0];
               irq_en_d = wdat[1];
               if (!wdat[0]) begin
                  len_d   = 8'd0;
                  irq_set = 1'b0;
               end
            end
            6'h04: if (wdat[1]) irq_d = 1'b0;
            default: ;
         endcase
      end
      if (irq_set) irq_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdiv_q      <= '0;
         qf_cnt_q    <= '0;
         apu_ph_q    <= 1'b0;
         hf_ph_q     <= 1'b0;
         ctrl_q      <= 8'd0;
         period_q    <= 11'd0;
         timer_q     <= 11'd0;
         step_q      <= 3'd0;
         enable_q    <= 1'b0;
         irq_en_q    <= 1'b0;
         irq_q       <= 1'b0;
         len_q       <= 8'd0;
         env_start_q <= 1'b0;
         decay_q     <= 4'd0;
         env_div_q   <= 4'd0;
         pwm_q       <= 4'd0;
      end else begin
         cdiv_q      <= cdiv_d;
         qf_cnt_q    <= qf_cnt_d;
         apu_ph_q    <= apu_ph_d;
         hf_ph_q     <= hf_ph_d;
         ctrl_q      <= ctrl_d;
         period_q    <= period_d;
         timer_q     <= timer_d;
         step_q      <= step_d;
         enable_q    <= enable_d;
         irq_en_q    <= irq_en_d;
         irq_q       <= irq_d;
         len_q       <= len_d;
         env_start_q <= env_start_d;
         decay_q     <= decay_d;
         env_div_q   <= env_div_d;
         pwm_q       <= pwm_d;
      end
   end

   always_comb begin
      duty_bit = DUTY_PAT[ctrl_q[7:6]][3'd7 - step_q];
      sample   = 4'd0;
      if (duty_bit && len_nz && (period_q >= 11'd8))
         sample = ctrl_q[4] ? ctrl_q[3:0] : decay_q;
   end

   always_comb begin
      case (address)
         6'h00:   rd_byte = ctrl_q;
         6'h01:   rd_byte = period_q[7:0];
         6'h02:   rd_byte = {5'b0, period_q[10:8]};
         6'h03:   rd_byte = {6'b0, irq_en_q, enable_q};
         6'h04:   rd_byte = {6'b0, irq_q, len_nz};
         default: rd_byte = 8'h00;
      endcase
   end

   assign uo_out         = {sample, 2'b00, (sample > pwm_q), 1'b0};
   assign data_out       = {24'h0, rd_byte};
   assign data_ready     = 1'b1;
   assign user_interrupt = irq_q;

endmodule
